mult2x2_seq_ctrl: RTL and testbench
===================================

Name: mult2x2_seq_ctrl

Overview:
Sequencer that reuses one 2x2 combinational multiplier to compute a WIDTH x WIDTH unsigned product.
- Splits both operands into 2-bit digits.
- Drives one digit pair per cycle onto the shared 2x2 datapath.
- Accumulates the shifted 4-bit partial products.
- Returns the 2*WIDTH-bit result over a valid/ready handshake.

Sits between a requesting datapath stage and the existing 2x2 multiplier block, which it drives through its mul_* ports.

Parameters:
- WIDTH, 8, operand width in bits; must be even, range 2..32. N = WIDTH/2 digits per operand.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- a_in  input  WIDTH  multiplicand, unsigned
- b_in  input  WIDTH  multiplier, unsigned
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  unsigned product a*b
- busy  output  1  high in BUSY or DONE
- mul_a  output  2  digit of A to the 2x2 multiplier
- mul_b  output  2  digit of B to the 2x2 multiplier
- mul_p  input  4  2x2 multiplier result; combinational function of mul_a/mul_b in the same cycle

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - product=0, mul_a=0, mul_b=0.
  - Digit indices i=j=0; accumulator=0.
  - Takes effect immediately, including mid-operation; the in-flight operation is discarded and no output is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, mul_a=mul_b=0.
  - On an edge with in_valid=1: latch a_in/b_in, clear accumulator, i=j=0, go to BUSY.
- BUSY:
  - in_ready=0, busy=1.
  - mul_a = A[2i+1:2i], mul_b = B[2j+1:2j] (registered operands).
  - Each edge: accumulator += zero-extend(mul_p) << 2*(i+j).
  - Accumulator is 2*WIDTH bits; no overflow is possible.
  - Index order: j is the inner index (0..N-1); when j wraps to 0, i increments.
  - After the edge that accumulates pair (N-1,N-1): go to DONE.
  - Exactly N*N BUSY cycles per operation.
- DONE:
  - out_valid=1, busy=1, product = accumulator, held stable while out_ready=0.
  - mul_a=mul_b=0.
  - On an edge with out_ready=1: go to IDLE and drop out_valid.
  - product keeps its last value until the next accept.
- Latency: out_valid rises N*N cycles after the accepting edge (WIDTH=8: 16 cycles; WIDTH=2: 1 cycle).
- Throughput: one operation per N*N+2 cycles minimum (accept, N*N BUSY, handshake).
- in_valid while not IDLE is ignored; operands are not captured and not queued.
- in_valid and out_ready may be high simultaneously in DONE: only the output handshake completes that edge. The new operand is accepted on a later IDLE edge.
- Operands are only sampled on the accept edge; later changes on a_in/b_in have no effect on the result.
- The accumulator update uses only mul_p; the controller never computes digit products itself.

Test Plan:
1. WIDTH=8, a=3, b=5, out_ready=1 → out_valid 16 cycles after accept; product=15; IDLE next cycle.
2. WIDTH=8, a=0xFF, b=0xFF → product=0xFE01. Also a=0xA5, b=0x3C → product=0x26AC. Also a=0, b=0x7F → product=0.
3. Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid → product=0x03A8 stable, out_valid held; drops one cycle after out_ready=1.
4. Accept a=7, b=9, then pulse in_valid with a=0xFF, b=0xFF during BUSY → ignored; product=63; in_ready=0 throughout BUSY/DONE.
5. Reset mid-operation: assert rst_n=0 at BUSY cycle 8 → all outputs zero immediately. After release, a=2, b=3 → product=6 with normal 16-cycle latency.
6. WIDTH=2, a=3, b=3 → out_valid one cycle after accept; product=9; mul_a=mul_b=3 during the single BUSY cycle.

Source files
------------

// File: rtl/mult2x2_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier that reuses an external 2x2 multiplier,
// feeding it one digit pair per cycle and summing the shifted partial products.
module mult2x2_seq_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy,
   output logic [1:0]           mul_a,
   output logic [1:0]           mul_b,
   input  logic [3:0]           mul_p
);

   localparam int N  = WIDTH / 2;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_r;
   logic [WIDTH-1:0]      a_r;
   logic [WIDTH-1:0]      b_r;
   logic [2*WIDTH-1:0]    acc_r;
   logic [IW-1:0]         i_r;
   logic [IW-1:0]         j_r;

   logic [IW:0]           sum_s;
   logic [2*WIDTH-1:0]    pp_s;
   logic [2*WIDTH-1:0]    acc_next_s;
   logic [IW-1:0]         i_inc_s;
   logic [IW-1:0]         j_inc_s;
   logic [1:0]            a_dig_s;
   logic [1:0]            b_dig_s;

   // Partial-product alignment and the digits presented on the next BUSY cycle.
   always_comb begin
      sum_s      = (IW+1)'(i_r) + (IW+1)'(j_r);
      pp_s       = (2*WIDTH)'(mul_p) << {sum_s, 1'b0};
      acc_next_s = acc_r + pp_s;
      i_inc_s    = i_r + IW'(1'b1);
      j_inc_s    = j_r + IW'(1'b1);
      a_dig_s    = 2'(a_r >> {i_inc_s, 1'b0});
      b_dig_s    = 2'(b_r >> {j_inc_s, 1'b0});
   end

   // Control FSM with registered handshake, status and multiplier-digit outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         acc_r     <= '0;
         i_r       <= '0;
         j_r       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         product   <= '0;
         mul_a     <= 2'b00;
         mul_b     <= 2'b00;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= a_in;
                  b_r      <= b_in;
                  acc_r    <= '0;
                  i_r      <= '0;
                  j_r      <= '0;
                  mul_a    <= a_in[1:0];
                  mul_b    <= b_in[1:0];
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state_r  <= BUSY;
               end else begin
                  mul_a    <= 2'b00;
                  mul_b    <= 2'b00;
                  in_ready <= 1'b1;
               end
            end
            BUSY: begin
               acc_r <= acc_next_s;
               if ((i_r == LAST_IDX) && (j_r == LAST_IDX)) begin
                  product   <= acc_next_s;
                  out_valid <= 1'b1;
                  mul_a     <= 2'b00;
                  mul_b     <= 2'b00;
                  state_r   <= DONE;
               end else if (j_r == LAST_IDX) begin
                  // j wraps: advance the A digit and restart B at its lowest digit
                  i_r   <= i_inc_s;
                  j_r   <= '0;
                  mul_a <= a_dig_s;
                  mul_b <= b_r[1:0];
               end else begin
                  j_r   <= j_inc_s;
                  mul_b <= b_dig_s;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
               mul_a     <= 2'b00;
               mul_b     <= 2'b00;
               state_r   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult2x2_seq_ctrl.sv
// Directed bench for mult2x2_seq_ctrl: WIDTH=8 and WIDTH=2 instances, each wired to a 2x2 multiplier model.
module tb_mult2x2_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0, out_ready = 1'b1;
   logic [7:0]  a_in = 8'd0, b_in = 8'd0;
   logic        in_ready, out_valid, busy;
   logic [15:0] product;
   logic [1:0]  mul_a, mul_b;
   logic [3:0]  mul_p;

   logic        in_valid2 = 1'b0, out_ready2 = 1'b1;
   logic [1:0]  a_in2 = 2'd0, b_in2 = 2'd0;
   logic        in_ready2, out_valid2, busy2;
   logic [3:0]  product2;
   logic [1:0]  mul_a2, mul_b2;
   logic [3:0]  mul_p2;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   assign mul_p  = {2'b00, mul_a}  * {2'b00, mul_b};
   assign mul_p2 = {2'b00, mul_a2} * {2'b00, mul_b2};

   mult2x2_seq_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .product(product), .busy(busy), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
   );

   mult2x2_seq_ctrl #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .a_in(a_in2), .b_in(b_in2), .out_valid(out_valid2), .out_ready(out_ready2),
      .product(product2), .busy(busy2), .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2)
   );

   // Present one operand pair for exactly one edge; returns #1 after the accepting edge.
   task automatic accept(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      a_in = a; b_in = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count cycles from the accepting edge until out_valid, bounded.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      total_cnt++;
      if ({in_ready, out_valid, busy, product, mul_a, mul_b} !== {1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00})
         $display("FAIL reset8: rdy=%b ov=%b busy=%b prod=%h ma=%0d mb=%0d, expected 1 0 0 0000 0 0",
                  in_ready, out_valid, busy, product, mul_a, mul_b);
      else pass_cnt++;
      total_cnt++;
      if ({in_ready2, out_valid2, busy2, product2} !== {1'b1, 1'b0, 1'b0, 4'h0})
         $display("FAIL reset2: rdy=%b ov=%b busy=%b prod=%h, expected 1 0 0 0",
                  in_ready2, out_valid2, busy2, product2);
      else pass_cnt++;
   endtask

   task automatic test_basic;
      int lat;
      out_ready = 1'b1;
      accept(8'd3, 8'd5);
      total_cnt++;
      if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL basic_busy: busy=%b rdy=%b, expected 1 0", busy, in_ready);
      else pass_cnt++;
      wait_valid(lat);
      total_cnt++;
      if (lat !== 16) $display("FAIL basic_latency: got %0d, expected 16", lat);
      else pass_cnt++;
      total_cnt++;
      if (product !== 16'd15) $display("FAIL basic_product: got %h, expected 000f", product);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
         $display("FAIL basic_idle: ov=%b rdy=%b busy=%b, expected 0 1 0", out_valid, in_ready, busy);
      else pass_cnt++;
   endtask

   task automatic test_patterns;
      logic [7:0]  av [3] = '{8'hFF, 8'hA5, 8'h00};
      logic [7:0]  bv [3] = '{8'hFF, 8'h3C, 8'h7F};
      logic [15:0] pv [3] = '{16'hFE01, 16'h26AC, 16'h0000};
      int lat;
      for (int k = 0; k < 3; k++) begin
         accept(av[k], bv[k]);
         wait_valid(lat);
         total_cnt++;
         if (product !== pv[k] || lat !== 16)
            $display("FAIL pattern%0d: product=%h lat=%0d, expected %h lat=16", k, product, lat, pv[k]);
         else pass_cnt++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure;
      int lat;
      out_ready = 1'b0;
      accept(8'h12, 8'h34);
      wait_valid(lat);
      for (int k = 0; k < 5; k++) begin
         total_cnt++;
         if (out_valid !== 1'b1 || product !== 16'h03A8)
            $display("FAIL bp_hold%0d: ov=%b product=%h, expected 1 03a8", k, out_valid, product);
         else pass_cnt++;
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      total_cnt++;
      if (out_valid !== 1'b1) $display("FAIL bp_still_valid: ov=%b, expected 1", out_valid);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid !== 1'b0 || product !== 16'h03A8)
         $display("FAIL bp_release: ov=%b product=%h, expected 0 03a8", out_valid, product);
      else pass_cnt++;
   endtask

   task automatic test_ignore_busy;
      int lat;
      int bad_rdy;
      accept(8'd7, 8'd9);
      bad_rdy = 0;
      lat = 0;
      while (!out_valid && lat < 100) begin
         if (in_ready !== 1'b0) bad_rdy++;
         if (lat == 3) begin
            a_in = 8'hFF; b_in = 8'hFF; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      // DONE with both in_valid and out_ready high: only the output handshake happens
      in_valid = 1'b1; a_in = 8'hFF; b_in = 8'hFF; out_ready = 1'b1;
      total_cnt++;
      if (product !== 16'd63 || lat !== 16 || in_ready !== 1'b0)
         $display("FAIL ignore_product: product=%h lat=%0d rdy=%b, expected 003f 16 0", product, lat, in_ready);
      else pass_cnt++;
      total_cnt++;
      if (bad_rdy !== 0) $display("FAIL ignore_in_ready: %0d busy cycles with in_ready high, expected 0", bad_rdy);
      else pass_cnt++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL ignore_done_accept: ov=%b busy=%b rdy=%b, expected 0 0 1", out_valid, busy, in_ready);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      int lat;
      accept(8'hAB, 8'hCD);
      repeat (8) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({in_ready, out_valid, busy, product, mul_a, mul_b} !== {1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 2'b00})
         $display("FAIL reset_mid: rdy=%b ov=%b busy=%b prod=%h ma=%0d mb=%0d, expected 1 0 0 0000 0 0",
                  in_ready, out_valid, busy, product, mul_a, mul_b);
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      accept(8'd2, 8'd3);
      wait_valid(lat);
      total_cnt++;
      if (product !== 16'd6 || lat !== 16)
         $display("FAIL reset_recover: product=%h lat=%0d, expected 0006 16", product, lat);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_width2;
      @(negedge clk);
      a_in2 = 2'd3; b_in2 = 2'd3; in_valid2 = 1'b1; out_ready2 = 1'b1;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      total_cnt++;
      if (mul_a2 !== 2'd3 || mul_b2 !== 2'd3 || busy2 !== 1'b1 || out_valid2 !== 1'b0)
         $display("FAIL w2_busy: ma=%0d mb=%0d busy=%b ov=%b, expected 3 3 1 0", mul_a2, mul_b2, busy2, out_valid2);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid2 !== 1'b1 || product2 !== 4'd9 || mul_a2 !== 2'd0)
         $display("FAIL w2_done: ov=%b product=%0d ma=%0d, expected 1 9 0", out_valid2, product2, mul_a2);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (out_valid2 !== 1'b0 || in_ready2 !== 1'b1)
         $display("FAIL w2_idle: ov=%b rdy=%b, expected 0 1", out_valid2, in_ready2);
      else pass_cnt++;
   endtask

   initial begin
      #12;
      test_reset;
      @(negedge clk);
      rst_n = 1'b1;
      test_basic;
      test_patterns;
      test_backpressure;
      test_ignore_busy;
      test_reset_mid;
      test_width2;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
